// File: rtl/mem_rw.sv
// mem_rw: single-port synchronous read/write memory with registered read data.
// A per-entry valid bit makes reads of entries not written since reset return
// RESET_RDATA, so the storage array itself never has to be cleared.
// Optional build macro: MEM_WR_FWD_EN selects write-first behaviour for a
// same-cycle read+write (default build is read-before-write).
module mem_rw #(
   parameter int                    ADDR_WIDTH  = 8,
   parameter int                    DATA_WIDTH  = 8,
   parameter logic [DATA_WIDTH-1:0] RESET_RDATA = '0
) (
   input  logic                  clk,
   input  logic                  rstn,   // synchronous, active-high despite the name
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] r_data
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0]      valid;
   logic [DATA_WIDTH-1:0] stored_data;

   // Value currently held at addr, with never-written entries masked out
   assign stored_data = valid[addr] ? mem[addr] : RESET_RDATA;

   // Storage array write; accesses in a reset cycle are dropped
   // NOTE: the array deliberately has no reset term -- the valid bits hide stale
   // contents, and leaving it unreset lets synthesis map it onto plain RAM.
   always_ff @(posedge clk) begin
      if (!rstn && wr_en) begin
         mem[addr] <= w_data;
      end
   end

   // Valid-bit tracking: cleared by reset, set on every accepted write
   // NOTE: sequential state uses non-blocking assignments so every register in
   // this block samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rstn) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[addr] <= 1'b1;
      end
   end

   // Registered read port; holds its value while rd_en is low
   always_ff @(posedge clk) begin
      if (rstn) begin
         r_data <= RESET_RDATA;
      end else if (rd_en) begin
`ifdef MEM_WR_FWD_EN
         // Write-first: a colliding write is forwarded straight to the output
         r_data <= wr_en ? w_data : stored_data;
`else
         // Read-before-write: stored_data reflects the pre-edge array and valid
         r_data <= stored_data;
`endif
      end
   end

endmodule

// File: tb/tb_mem_rw.sv
// tb_mem_rw: directed, self-checking bench for mem_rw. Expected read data is
// pushed to a scoreboard queue when a read is issued and popped/compared once
// the registered output has updated. Outputs are sampled 1 ns after the edge.
module tb_mem_rw;

   logic       clk;
   logic       rstn;
   logic       wr_en;
   logic [7:0] w_data;
   logic [7:0] addr;
   logic       rd_en;
   logic [7:0] r_data;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] exp;
      string      tag;
   } exp_t;

   exp_t sb[$];

   mem_rw #(
      .ADDR_WIDTH  (8),
      .DATA_WIDTH  (8),
      .RESET_RDATA (8'h00)
   ) dut (
      .clk    (clk),
      .rstn   (rstn),
      .wr_en  (wr_en),
      .w_data (w_data),
      .addr   (addr),
      .rd_en  (rd_en),
      .r_data (r_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it, and counts/report a failure
   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle of stimulus; a read pushes its expectation and is checked
   // right after the edge that registers it
   task automatic access(input logic w, input logic r, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] exp, input string tag);
      exp_t e;
      wr_en  = w;
      rd_en  = r;
      addr   = a;
      w_data = d;
      if (r) begin
         e.exp = exp;
         e.tag = tag;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      if (r) begin
         e = sb.pop_front();
         check(e.tag, r_data, e.exp);
      end
   endtask

   task automatic do_reset(input int cycles);
      rstn = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      rstn = 1'b0;
   endtask

   logic [7:0] collide_exp;
   logic [7:0] invalid_collide_exp;

   initial begin
      rstn   = 1'b1;
      wr_en  = 1'b0;
      rd_en  = 1'b0;
      addr   = '0;
      w_data = '0;

`ifdef MEM_WR_FWD_EN
      collide_exp         = 8'h22;
      invalid_collide_exp = 8'h6B;
`else
      collide_exp         = 8'h11;
      invalid_collide_exp = 8'h00;
`endif

      // Reset state
      do_reset(2);
      check("reset_rdata", r_data, 8'h00);

      // Contents written before a reset must not show afterwards
      access(1, 0, 8'h00, 8'hEE, 8'h00, "");
      access(0, 1, 8'h00, 8'h00, 8'hEE, "pre_reset_data");
      do_reset(2);
      check("reset_clears_rdata", r_data, 8'h00);
      access(0, 1, 8'h00, 8'h00, 8'h00, "reset_hides_addr00");

      // Write then back-to-back readback, then hold for 3 idle cycles
      access(1, 0, 8'h10, 8'hA5, 8'h00, "");
      access(0, 1, 8'h10, 8'h00, 8'hA5, "readback_10");
      for (int i = 0; i < 3; i++) begin
         access(0, 0, 8'(i * 7), 8'h00, 8'h00, "");
         check("hold_idle", r_data, 8'hA5);
      end
      // A write without rd_en must not disturb r_data either
      access(1, 0, 8'h11, 8'h55, 8'h00, "");
      check("hold_during_write", r_data, 8'hA5);

      // Unwritten location
      do_reset(1);
      access(1, 0, 8'h01, 8'h3C, 8'h00, "");
      access(0, 1, 8'hFF, 8'h00, 8'h00, "unwritten_FF");
      access(0, 1, 8'h01, 8'h00, 8'h3C, "written_01");
      access(0, 1, 8'h10, 8'h00, 8'h00, "stale_10_after_reset");

      // Full sweep, boundaries included
      for (int a = 0; a < 256; a++) begin
         access(1, 0, 8'(a), 8'(a) ^ 8'h5A, 8'h00, "");
      end
      for (int a = 0; a < 256; a++) begin
         access(0, 1, 8'(a), 8'h00, 8'(a) ^ 8'h5A, "sweep");
      end

      // Overwrite keeps the entry valid with new data
      access(1, 0, 8'hFF, 8'hC3, 8'h00, "");
      access(0, 1, 8'hFF, 8'h00, 8'hC3, "overwrite_FF");

      // Same-cycle read+write collision on a valid entry
      access(1, 0, 8'h20, 8'h11, 8'h00, "");
      access(1, 1, 8'h20, 8'h22, collide_exp, "collision_valid");
      access(0, 1, 8'h20, 8'h00, 8'h22, "after_collision");

      // Collision on an entry invalidated by reset
      do_reset(1);
      access(1, 1, 8'h30, 8'h6B, invalid_collide_exp, "collision_invalid");
      access(0, 1, 8'h30, 8'h00, 8'h6B, "after_collision_invalid");

      // Mid-operation reset clears the valid bit
      access(1, 0, 8'h40, 8'h77, 8'h00, "");
      do_reset(1);
      access(0, 1, 8'h40, 8'h00, 8'h00, "midop_reset_40");

      // A write issued in the reset cycle is dropped
      rstn   = 1'b1;
      wr_en  = 1'b1;
      addr   = 8'h50;
      w_data = 8'h99;
      @(posedge clk);
      #1;
      rstn  = 1'b0;
      wr_en = 1'b0;
      access(0, 1, 8'h50, 8'h00, 8'h00, "write_in_reset_dropped");

      // First access after release is accepted
      access(1, 0, 8'h50, 8'h9A, 8'h00, "");
      access(0, 1, 8'h50, 8'h00, 8'h9A, "first_after_release");

      check("scoreboard_empty", 8'(sb.size()), 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
